usb_tx_buffer: RTL

Transmit-side data buffer for the USB bulk endpoint. It accepts 1-, 2- or 4-byte writes from the AHB-Lite slave and holds up to DEPTH bytes in FIFO order. It presents the head byte to `usb_tx`, which pops one byte per `get_tx_packet_data` pulse while serialising a DATA packet. Its occupancy drives `usb_tx`'s `tx_packet_size`.

---
 rtl/usb_pkg.sv | 23 ++
 rtl/usb_tx_buffer_mem.sv | 28 ++
 rtl/usb_tx_buffer.sv | 116 +++++++++++
 3 files changed

// File: rtl/usb_pkg.sv
// Shared USB definitions: transfer size encodings and the transmit buffer depth.
// Used by the AHB slave, usb_tx and usb_tx_buffer.
package usb_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } tx_size_t;

  localparam int unsigned TX_BUFFER_DEPTH = 64;

  // Byte count of a write; 0 marks the reserved encoding.
  function automatic logic [2:0] tx_size_len(input logic [1:0] size);
    case (size)
      SIZE_BYTE: tx_size_len = 3'd1;
      SIZE_HALF: tx_size_len = 3'd2;
      SIZE_WORD: tx_size_len = 3'd4;
      default:   tx_size_len = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/usb_tx_buffer_mem.sv
// Byte-wide register array for the TX buffer: one 4-lane write port with
// per-lane wrapping addresses and one asynchronous read port.
module usb_tx_buffer_mem #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] wr_base_i,
  input  logic [3:0]    wr_lane_en_i,
  input  logic [31:0]   wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_c
);

  logic [7:0] mem_q [DEPTH];

  // Lane l lands at base + l; the AW-bit add wraps at the end of the array.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (wr_lane_en_i[l]) begin
        mem_q[wr_base_i + AW'(l)] <= wr_data_i[8*l +: 8];
      end
    end
  end

  assign rd_data_c = mem_q[rd_addr_i];

endmodule

// File: rtl/usb_tx_buffer.sv
// USB bulk endpoint transmit FIFO: 1/2/4-byte writes in, show-ahead byte pops out.
// Define USB_TX_BUFFER_ERR_EN to add the sticky buffer_error flag.
module usb_tx_buffer
  import usb_pkg::*;
#(
  parameter int unsigned DEPTH = TX_BUFFER_DEPTH
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   clear,
  input  logic                   store_tx_data,
  input  logic [31:0]            tx_data,
  input  logic [1:0]             tx_data_size,
  input  logic                   get_tx_packet_data,
  output logic [7:0]             tx_packet_data,
  output logic [$clog2(DEPTH):0] buffer_occupancy,
  output logic                   buffer_full,
  output logic                   buffer_empty
`ifdef USB_TX_BUFFER_ERR_EN
  ,
  output logic                   buffer_error
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [2:0]    wr_len;
  logic [3:0]    lane_en;
  logic          wr_fit, wr_ok, pop_ok;
  logic [7:0]    rd_data;

  // Write acceptance uses occupancy before any same-cycle pop.
  always_comb begin
    wr_len  = tx_size_len(tx_data_size);
    lane_en = 4'b0000;
    case (wr_len)
      3'd1:    lane_en = 4'b0001;
      3'd2:    lane_en = 4'b0011;
      3'd4:    lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
    wr_fit = ({1'b0, occ_q} + (OW+1)'(wr_len)) <= (OW+1)'(DEPTH);
    wr_ok  = store_tx_data && (wr_len != 3'd0) && wr_fit;
    pop_ok = get_tx_packet_data && (occ_q != '0);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (wr_ok)  wr_ptr_d = wr_ptr_q + AW'(wr_len);
      if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      occ_d = occ_q + (wr_ok ? OW'(wr_len) : '0) - (pop_ok ? OW'(1) : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  usb_tx_buffer_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk          (clk),
    .wr_base_i    (wr_ptr_q),
    .wr_lane_en_i (lane_en & {4{wr_ok & ~clear}}),
    .wr_data_i    (tx_data),
    .rd_addr_i    (rd_ptr_q),
    .rd_data_c    (rd_data)
  );

  assign tx_packet_data   = (occ_q != '0) ? rd_data : 8'h00;
  assign buffer_occupancy = occ_q;
  assign buffer_full      = (occ_q == OW'(DEPTH));
  assign buffer_empty     = (occ_q == '0);

`ifdef USB_TX_BUFFER_ERR_EN
  logic err_q, err_d;

  // Sticky on rejected writes and empty pops; clear takes precedence.
  always_comb begin
    err_d = err_q;
    if (clear) begin
      err_d = 1'b0;
    end else if ((store_tx_data && !wr_ok) || (get_tx_packet_data && (occ_q == '0))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign buffer_error = err_q;
`endif

endmodule
